// File: rtl/n64_sync_gen_if.sv
// n64_sync_gen_if: 4-bit N64 sync bus plus its pixel-tick strobe and field flag.
// The generator drives it through the master modport; PPU-side consumers use slave.
interface n64_sync_gen_if;
  logic       vsync_valid_o;
  logic [3:0] vsync_o;        // {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  logic       field_o;

  modport master (output vsync_valid_o, output vsync_o, output field_o);
  modport slave  (input  vsync_valid_o, input  vsync_o, input  field_o);
endinterface

// File: rtl/n64_sync_gen.sv
// n64_sync_gen: standalone N64-style sync stream generator (NTSC/PAL, 240p/288p).
// A DIV-cycle divider produces pixel ticks; on each tick the line/pixel counters
// advance and the registered sync word is recomputed from the new position.
// Optional feature macro: SYNCGEN_INTERLACE_EN (alternating fields with the
// odd-field vsync shifted by half a line). Without it the output is progressive
// and field_o is tied low.
module n64_sync_gen #(
  parameter int unsigned DIV          = 4,
  parameter logic [9:0]  H_TOTAL_NTSC = 10'd773,
  parameter logic [9:0]  H_TOTAL_PAL  = 10'd794,
  parameter logic [8:0]  V_TOTAL_NTSC = 9'd263,
  parameter logic [8:0]  V_TOTAL_PAL  = 9'd313,
  parameter logic [9:0]  HSYNC_LEN    = 10'd57,
  parameter logic [9:0]  CLAMP_START  = 10'd64,
  parameter logic [9:0]  CLAMP_LEN    = 10'd28,
  parameter logic [8:0]  VSYNC_LEN    = 9'd3
) (
  input  logic           VCLK,
  input  logic           nRST,
  input  logic           en,
  input  logic           palmode,
  input  logic           interlaced,
  n64_sync_gen_if.master sync
);

  localparam int unsigned    DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q;
  logic [9:0]    hcnt_q, hcnt_n, h_total;
  logic [8:0]    vcnt_q, vcnt_n, v_total;
  logic          pal_q, pal_n, fresh_q;
  logic          tick, line_end, frame_end;
  logic          n_hs, n_vs, n_cl, n_cs;

`ifdef SYNCGEN_INTERLACE_EN
  logic          field_q, field_n;
  logic [9:0]    h_half;
`else
  logic          unused_interlaced;
  assign unused_interlaced = interlaced;
`endif

  // Frame geometry for the latched mode and the next counter position
  always_comb begin
    h_total = pal_q ? H_TOTAL_PAL : H_TOTAL_NTSC;
    v_total = pal_q ? V_TOTAL_PAL : V_TOTAL_NTSC;
`ifdef SYNCGEN_INTERLACE_EN
    if (field_q) v_total = v_total - 9'd1;
`endif
    tick      = en && (div_q == DIV_LAST);
    line_end  = (hcnt_q == h_total - 10'd1);
    frame_end = line_end && (vcnt_q == v_total - 9'd1);
    hcnt_n    = line_end ? '0 : hcnt_q + 10'd1;
    if (frame_end)     vcnt_n = '0;
    else if (line_end) vcnt_n = vcnt_q + 9'd1;
    else               vcnt_n = vcnt_q;
    pal_n     = frame_end ? palmode : pal_q;
  end

  // Sync levels for the position the counters move to on this tick
  always_comb begin
    n_hs = !(hcnt_n < HSYNC_LEN);
`ifdef SYNCGEN_INTERLACE_EN
    field_n = frame_end ? (interlaced & ~field_q) : field_q;
    h_half  = (pal_n ? H_TOTAL_PAL : H_TOTAL_NTSC) >> 1;
    // odd field: vsync window spans (0,h_half) .. (VSYNC_LEN,h_half)
    if (field_n)
      n_vs = !(((vcnt_n == '0) && (hcnt_n >= h_half)) ||
               ((vcnt_n != '0) && (vcnt_n < VSYNC_LEN)) ||
               ((vcnt_n == VSYNC_LEN) && (hcnt_n < h_half)));
    else
      n_vs = !(vcnt_n < VSYNC_LEN);
`else
    n_vs = !(vcnt_n < VSYNC_LEN);
`endif
    n_cl = !((hcnt_n >= CLAMP_START) && (hcnt_n < CLAMP_START + CLAMP_LEN) && n_vs);
    n_cs = n_vs ? n_hs : ~n_hs;
  end

  // Divider, position counters, mode latch and registered sync word
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      div_q              <= '0;
      hcnt_q             <= '0;
      vcnt_q             <= '0;
      pal_q              <= 1'b0;
      fresh_q            <= 1'b1;
      sync.vsync_valid_o <= 1'b0;
      sync.vsync_o       <= '1;
    end else begin
      sync.vsync_valid_o <= tick;
      if (en) div_q <= tick ? '0 : div_q + DW'(1);
      // the first cycle after release stands in for a frame wrap
      if (fresh_q) begin
        fresh_q <= 1'b0;
        pal_q   <= palmode;
      end
      if (tick) begin
        hcnt_q       <= hcnt_n;
        vcnt_q       <= vcnt_n;
        pal_q        <= pal_n;
        sync.vsync_o <= {n_vs, n_cl, n_hs, n_cs};
      end
    end
  end

`ifdef SYNCGEN_INTERLACE_EN
  // Field flag follows the position counters
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST)     field_q <= 1'b0;
    else if (tick) field_q <= field_n;
  end
  assign sync.field_o = field_q;
`else
  assign sync.field_o = 1'b0;
`endif

endmodule

// File: tb/tb_n64_sync_gen.sv
// tb_n64_sync_gen: bench for n64_sync_gen with a shrunk frame geometry so whole
// frames fit in a short run. A position-in-frame reference model predicts the
// strobe and sync word every cycle; frame/vsync lengths are measured from edges.
module tb_n64_sync_gen;

  localparam int unsigned DIV = 4;
  localparam int unsigned HN  = 120;
  localparam int unsigned HP  = 130;
  localparam int unsigned VN  = 11;
  localparam int unsigned VP  = 13;
  localparam int unsigned HS  = 10;
  localparam int unsigned CS  = 14;
  localparam int unsigned CL  = 6;
  localparam int unsigned VS  = 3;

  logic VCLK = 1'b0;
  logic nRST = 1'b0;
  logic en = 1'b0;
  logic palmode = 1'b0;
  logic interlaced = 1'b0;

  n64_sync_gen_if sync_if ();

  n64_sync_gen #(
    .DIV(DIV),
    .H_TOTAL_NTSC(10'(HN)), .H_TOTAL_PAL(10'(HP)),
    .V_TOTAL_NTSC(9'(VN)),  .V_TOTAL_PAL(9'(VP)),
    .HSYNC_LEN(10'(HS)), .CLAMP_START(10'(CS)), .CLAMP_LEN(10'(CL)),
    .VSYNC_LEN(9'(VS))
  ) dut (
    .VCLK(VCLK),
    .nRST(nRST),
    .en(en),
    .palmode(palmode),
    .interlaced(interlaced),
    .sync(sync_if)
  );

  always #5 VCLK = ~VCLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       en;
    logic       exp_valid;
    logic [3:0] exp_vs;
  } vec_t;
  vec_t tbl[10];

  // reference model state: enabled-cycle count and tick position within the frame
  int         m_ecnt, m_pix;
  bit         m_pal, m_fresh, m_valid;
  logic [3:0] m_vs;

  // edge tracking on observed outputs
  int         tick_cnt;
  logic [3:0] prev_vs;
  int         falls[$];
  int         vlow[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int htot(input bit p);
    return p ? HP : HN;
  endfunction

  function automatic int vtot(input bit p);
    return p ? VP : VN;
  endfunction

  function automatic logic [3:0] sync_word(input int h, input int v);
    logic nh, nv, nc, ncs;
    nh  = (h >= HS);
    nv  = (v >= VS);
    nc  = !(nv && h >= CS && h < CS + CL);
    ncs = nv ? nh : !nh;
    return {nv, nc, nh, ncs};
  endfunction

  task automatic model_reset();
    m_ecnt = 0; m_pix = 0; m_fresh = 1; m_pal = 0; m_valid = 0; m_vs = 4'hF;
    tick_cnt = 0; prev_vs = 4'hF;
    falls.delete(); vlow.delete();
  endtask

  task automatic model_step();
    bit t;
    if (m_fresh) begin m_pal = palmode; m_fresh = 0; end
    t = en && ((m_ecnt % DIV) == DIV - 1);
    if (en) m_ecnt++;
    m_valid = t;
    if (t) begin
      m_pix++;
      if (m_pix == htot(m_pal) * vtot(m_pal)) begin
        m_pix = 0;
        m_pal = palmode;
      end
      m_vs = sync_word(m_pix % htot(m_pal), m_pix / htot(m_pal));
    end
  endtask

  // one clock: advance model, compare, track edges
  task automatic cyc();
    logic [3:0] cur;
    @(posedge VCLK);
    #1;
    model_step();
    check("cycle", {sync_if.vsync_valid_o, sync_if.vsync_o, sync_if.field_o},
          {m_valid, m_vs, 1'b0});
    cur = sync_if.vsync_o;
    if (sync_if.vsync_valid_o) tick_cnt++;
    if (prev_vs[3] && !cur[3]) begin
      check("vfall_with_hfall", {prev_vs[1], cur[1]}, 2'b10);
      falls.push_back(tick_cnt);
    end
    if (!prev_vs[3] && cur[3] && falls.size() > 0) vlow.push_back(tick_cnt - falls[$]);
    prev_vs = cur;
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired, got no event expected event", name);
  endtask

  task automatic run_until_falls(input int n, input int budget, input string name);
    int i = 0;
    while (falls.size() < n && i < budget) begin cyc(); i++; end
    if (falls.size() < n) timeout(name);
  endtask

  task automatic do_reset(input bit pal);
    @(posedge VCLK);
    #3;
    nRST = 1'b0; en = 1'b0; palmode = pal;
    #1;
    check("async_reset", {sync_if.vsync_valid_o, sync_if.vsync_o, sync_if.field_o},
          {1'b0, 4'hF, 1'b0});
    repeat (2) @(posedge VCLK);
    #1;
    nRST = 1'b1;
    model_reset();
  endtask

  initial begin
    // first cycles after release, NTSC, hand-derived: tick on 4th enabled cycle
    tbl[0] = '{1'b1, 1'b0, 4'hF};
    tbl[1] = '{1'b1, 1'b0, 4'hF};
    tbl[2] = '{1'b0, 1'b0, 4'hF};
    tbl[3] = '{1'b1, 1'b0, 4'hF};
    tbl[4] = '{1'b1, 1'b1, 4'h5};
    tbl[5] = '{1'b1, 1'b0, 4'h5};
    tbl[6] = '{1'b1, 1'b0, 4'h5};
    tbl[7] = '{1'b1, 1'b0, 4'h5};
    tbl[8] = '{1'b1, 1'b1, 4'h5};
    tbl[9] = '{1'b0, 1'b0, 4'h5};

    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      @(posedge VCLK);
      #1;
      check($sformatf("table[%0d]", i),
            {sync_if.vsync_valid_o, sync_if.vsync_o, sync_if.field_o},
            {tbl[i].exp_valid, tbl[i].exp_vs, 1'b0});
    end

    // NTSC frame length and vsync width
    do_reset(1'b0);
    en = 1'b1;
    run_until_falls(3, 4 * 3 * HN * VN + 100, "ntsc_frames");
    if (falls.size() >= 3) check("ntsc_frame_ticks", falls[2] - falls[1], HN * VN);
    if (vlow.size() >= 2)  check("ntsc_vsync_ticks", vlow[$], VS * HN);

    // palmode change mid-frame takes effect only at the next frame
    begin
      int i = 0;
      while (falls.size() > 0 && (tick_cnt - falls[$]) < 5 * HN + 7 && i < 4 * HN * VN) begin
        cyc(); i++;
      end
    end
    palmode = 1'b1;
    run_until_falls(5, 4 * (HN * VN + HP * VP) + 100, "pal_switch");
    if (falls.size() >= 5) begin
      check("switch_frame_ticks", falls[3] - falls[2], HN * VN);
      check("pal_frame_ticks", falls[4] - falls[3], HP * VP);
    end
    if (vlow.size() >= 4) check("pal_vsync_ticks", vlow[$], VS * HP);

    // freeze mid-line for 37 cycles
    begin
      int i = 0;
      int nvalid = 0;
      int nchg = 0;
      logic [3:0] held;
      while (falls.size() > 0 && (tick_cnt - falls[$]) < 40 && i < 400) begin cyc(); i++; end
      en = 1'b0;
      held = sync_if.vsync_o;
      for (int k = 0; k < 37; k++) begin
        cyc();
        if (sync_if.vsync_valid_o) nvalid++;
        if (sync_if.vsync_o !== held) nchg++;
      end
      check("freeze_valid_count", nvalid, 0);
      check("freeze_vsync_changes", nchg, 0);
      en = 1'b1;
      repeat (40) cyc();
    end

    // async reset mid-line, then randomized enable/mode traffic
    do_reset(1'b1);
    en = 1'b1;
    for (int k = 0; k < 15000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) palmode = ~palmode;
`ifndef SYNCGEN_INTERLACE_EN
      interlaced = 1'($urandom_range(0, 1));
`endif
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
